// File: rtl/serv_bufreg_pkg.sv
// Shared encodings and helpers for the serial buffer register.
package serv_bufreg_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSV  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // A half access must be 2-byte aligned, a word access 4-byte aligned.
    function automatic logic misalign(input logic [1:0] size, input logic [1:0] lsb);
        logic r;
        r = 1'b0;
        case (size_e'(size))
            SIZE_HALF: r = lsb[0];
            SIZE_WORD: r = |lsb;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/serv_serial_adder.sv
// W-bit slice adder with a carry register that links consecutive beats.
module serv_serial_adder #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic         first,
    input  logic         clr_lsb,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] q
);

    logic         carry;
    logic         carry_in;
    logic [W:0]   sum_full;

    // Beat 0 never sees a stale carry; clr_lsb only masks bit 0 of that first beat.
    always_comb begin
        carry_in = first ? 1'b0 : carry;
        sum_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_in};
        q        = sum_full[W-1:0];
        if (first && clr_lsb) begin
            q[0] = 1'b0;
        end
    end

    // Carry advances only on enabled beats and is wiped when a pass starts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry <= 1'b0;
        end else if (clr) begin
            carry <= 1'b0;
        end else if (en) begin
            carry <= sum_full[W];
        end
    end

endmodule

// File: rtl/serv_bufreg_p.sv
// Buffer register: serial rs1+imm accumulate, optional counted right shift,
// start/valid/ack handshake around the result.
module serv_bufreg_p
    import serv_bufreg_pkg::*;
#(
    parameter int W    = 1,
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [1:0]      i_mode,
    input  logic [4:0]      i_shamt,
    input  logic [1:0]      i_size,
    input  logic            i_en,
    input  logic            i_rs1_en,
    input  logic            i_imm_en,
    input  logic            i_clr_lsb,
    input  logic [W-1:0]    i_rs1,
    input  logic [W-1:0]    i_imm,
    input  logic            i_ack,
    output logic            o_busy,
    output logic            o_valid,
    output logic [W-1:0]    o_q,
    output logic [1:0]      o_lsb,
    output logic [XLEN-1:0] o_dbus_adr,
    output logic [XLEN-1:0] o_ext_rs1,
    output logic            o_misalign
);

    localparam int BEATS = XLEN / W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_e          state;
    state_e          state_nxt;
    mode_e           mode_r;
    logic [4:0]      shamt_r;
    logic [1:0]      size_r;
    logic [CNT_W-1:0] beat_cnt;
    logic [4:0]      shift_cnt;
    logic [XLEN-1:0] data;
    logic [1:0]      lsb_r;
    logic [1:0]      lsb_nxt;
    logic [W-1:0]    sum;

    logic accept;
    logic load_beat;
    logic shift_beat;
    logic last_beat;
    logic shift_req;
    logic fill;

    assign accept     = i_start && ((state == ST_IDLE) || (state == ST_DONE && i_ack));
    assign load_beat  = (state == ST_LOAD) && i_en;
    assign shift_beat = (state == ST_SHIFT) && i_en;
    assign last_beat  = (beat_cnt == CNT_W'(BEATS - 1));
    assign shift_req  = ((mode_r == MODE_SRL) || (mode_r == MODE_SRA)) && (shamt_r != 5'd0);
    assign fill       = (mode_r == MODE_SRA) ? data[XLEN-1] : 1'b0;

    serv_serial_adder #(.W(W)) u_adder (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .clr     (accept),
        .en      (load_beat),
        .first   (beat_cnt == '0),
        .clr_lsb (i_clr_lsb),
        .a       (i_rs1 & {W{i_rs1_en}}),
        .b       (i_imm & {W{i_imm_en}}),
        .q       (sum)
    );

    generate
        if (W == 1) begin : g_lsb_serial
            // With one bit per beat the two low address bits arrive on beats 0 and 1.
            always_comb begin
                lsb_nxt = lsb_r;
                if (beat_cnt == CNT_W'(0)) begin
                    lsb_nxt[0] = sum[0];
                end else if (beat_cnt == CNT_W'(1)) begin
                    lsb_nxt[1] = sum[0];
                end
            end
        end else begin : g_lsb_wide
            // Wider slices deliver both low address bits on beat 0.
            always_comb begin
                lsb_nxt = lsb_r;
                if (beat_cnt == CNT_W'(0)) begin
                    lsb_nxt = sum[1:0];
                end
            end
        end
    endgenerate

    // Phase sequencing: accumulate, optionally shift, then wait for the consumer.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (i_start) state_nxt = ST_LOAD;
            ST_LOAD:  if (i_en && last_beat) state_nxt = shift_req ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (i_en && shift_cnt == 5'd1) state_nxt = ST_DONE;
            ST_DONE:  if (i_ack) state_nxt = i_start ? ST_LOAD : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State, captured operands, counters and the data word itself.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            mode_r    <= MODE_ADD;
            shamt_r   <= 5'd0;
            size_r    <= 2'd0;
            beat_cnt  <= '0;
            shift_cnt <= 5'd0;
            data      <= '0;
            lsb_r     <= 2'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mode_r    <= mode_e'(i_mode);
                shamt_r   <= i_shamt;
                size_r    <= i_size;
                beat_cnt  <= '0;
                shift_cnt <= i_shamt;
            end else if (load_beat) begin
                data     <= {sum, data[XLEN-1:W]};
                beat_cnt <= beat_cnt + CNT_W'(1);
                lsb_r    <= lsb_nxt;
            end else if (shift_beat) begin
                data      <= {fill, data[XLEN-1:1]};
                shift_cnt <= shift_cnt - 5'd1;
            end
        end
    end

    assign o_busy     = (state == ST_LOAD) || (state == ST_SHIFT);
    assign o_valid    = (state == ST_DONE);
    assign o_q        = sum;
    assign o_lsb      = lsb_r;
    assign o_dbus_adr = {data[XLEN-1:2], 2'b00};
    assign o_ext_rs1  = data;
    assign o_misalign = (state == ST_DONE) && misalign(size_r, lsb_r);

endmodule

// File: doc/serv_bufreg_p.md
# serv_bufreg_p

Parametrised buffer register for the SERV datapath: serially accumulates `rs1 + imm` at W bits per beat, then optionally performs a counted logical or arithmetic right shift. It owns its own beat counter, phase state machine and start/valid/ack handshake, so the control unit needs no `cnt0`/`cnt1` decoding. The result drives the data-bus address, the extended rs1 value and a load/store misalignment flag.

## Interface
- `W`, 1: bits per beat; legal values 1, 2, 4, 8.
- `XLEN`, 32: register width; must be a multiple of W. `BEATS = XLEN/W`.
- `i_clk` in 1: clock, rising edge.
- `i_rst_n` in 1: reset, synchronous, active-low.
- `i_start` in 1: pulse that begins a pass; accepted only in IDLE, or in DONE together with `i_ack`.
- `i_mode` in 2: captured at start. 00 ADD, 01 SRL, 10 SRA, 11 reserved (treated as ADD).
- `i_shamt` in 5: shift amount, captured at start; ignored in ADD.
- `i_size` in 2: access size, captured at start. 00 byte, 01 half, 10 word.
- `i_en` in 1: beat enable; low freezes LOAD and SHIFT.
- `i_rs1_en`, `i_imm_en` in 1: operand gates.
- `i_clr_lsb` in 1: force sum bit 0 to 0 on beat 0.
- `i_rs1`, `i_imm` in W: operand slices, LSB first.
- `i_ack` in 1: consumer accepts the result.
- `o_busy` out 1: high in LOAD or SHIFT.
- `o_valid` out 1: high in DONE.
- `o_q` out W: current-beat sum, combinational.
- `o_lsb` out 2: bits [1:0] of the loaded sum.
- `o_dbus_adr` out XLEN: `{data[XLEN-1:2], 2'b00}`.
- `o_ext_rs1` out XLEN: `data`.
- `o_misalign` out 1: half access with `lsb[0]`=1, or word access with `lsb`≠0; 0 outside DONE.

## Operation
- States: IDLE → LOAD → (SHIFT) → DONE → IDLE.
- IDLE: `i_start` latches mode, shamt and size, clears the beat counter and carry, and moves to LOAD.
- LOAD, per `i_en` beat:
  - `sum = (i_rs1 & rs1_en) + (i_imm & imm_en) + carry`; carry register takes the carry out.
  - Beat 0 with `i_clr_lsb`: sum bit 0 is forced to 0.
  - `data <= {sum, data[XLEN-1:W]}`.
  - `o_lsb` is captured from bits [1:0] of the word. For W=1 these come from beats 0 and 1.
  - After beat BEATS-1: go to SHIFT if mode is SRL/SRA and shamt≠0, otherwise to DONE.
  - The carry out of the top beat is discarded (wrap-around modulo 2^XLEN).
- SHIFT, per `i_en` cycle:
  - `data <= {fill, data[XLEN-1:1]}`; fill is 0 for SRL, `data[XLEN-1]` for SRA.
  - Shift counter decrements; go to DONE when it reaches 0.
  - `o_lsb` is not updated.
- DONE: outputs held stable.
  - `i_ack` → IDLE.
  - `i_ack` and `i_start` in the same cycle → new pass (LOAD) next cycle, with new operands captured.
- `i_start` in LOAD or SHIFT is ignored.
- `i_en` is ignored in IDLE and DONE.

## Timing
- Reset values: state IDLE; data, carry and counters 0; all outputs 0.
- Start accepted at edge k. Beats occupy the enabled cycles after k.
- With `i_en` held high, `o_valid` rises after edge k+BEATS+shamt (shamt = 0 for ADD).
- Each `i_en`-low cycle adds one cycle of latency. Data, carry and counters hold.
- `o_q` reflects the current inputs combinationally.
- `o_dbus_adr`, `o_ext_rs1` and `o_lsb` are registered. They are valid only while `o_valid` is high.
- Reset low at any edge, mid-pass included, returns to reset values on that edge. A start in the same cycle is discarded.

## Structure
- Package `serv_bufreg_pkg` holds:
  - mode encodings, size encodings and state encodings;
  - helper function `misalign(size, lsb)`.
- One sub-module, `serv_serial_adder`: W-bit adder with registered carry, clear on beat 0, hold when not enabled, and `clr_lsb` gating.

## Test plan
- W=4, ADD, rs1=0x1000_0003, imm=0x0000_0005, size=word → DONE at cycle start+8; `o_ext_rs1`=0x1000_0008, `o_lsb`=0, `o_misalign`=0.
- W=1, ADD, rs1=0x0000_0101, imm=0x4, `i_clr_lsb`=1, size=half → `o_ext_rs1`=0x0000_0104, `o_dbus_adr`=0x0000_0104, `o_misalign`=0. Repeat with `clr_lsb`=0 → 0x0000_0105, `o_lsb`=1, `o_misalign`=1.
- W=2, SRA, rs1=0x8000_0010, `imm_en`=0, shamt=4 → 0xF800_0001 at start+16+4. Same stimulus with SRL → 0x0800_0001. With shamt=0 → 0x8000_0010 at start+16.
- W=8, ADD, rs1=0xFFFF_FFFF, imm=1 → 0x0000_0000 (wrap). Drop `i_en` for 3 cycles mid-load → same result, `o_valid` 3 cycles later.
- Handshake: `i_start` during LOAD is ignored. `i_start`+`i_ack` in DONE → new pass with no IDLE cycle. Hold DONE 5 cycles without ack → outputs stable.
- Reset: assert `i_rst_n`=0 mid-SHIFT → next cycle IDLE, all outputs 0. A following pass is unaffected by the old carry or data.
